// File: rtl/bcd_game_timer.sv
// BCD turn/round timer: prescaled tick, up/down BCD count, run control.
// Packed BCD output drives the display scanner directly.
module bcd_game_timer #(
   parameter int unsigned TICK_DIV = 5_000_000,
   parameter int unsigned DIGITS   = 8,
   parameter bit          COUNT_UP = 1'b0
) (
   input  logic                  clk_in,
   input  logic                  reset_btn,
   input  logic                  start,
   input  logic                  pause,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  dir_up,
   output logic [4*DIGITS-1:0]   number,
   output logic                  running,
   output logic                  tick,
   output logic                  expired,
   output logic                  wrapped
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PMAX  = PW'(TICK_DIV - 1);
   localparam logic [W-1:0]  NINES = {DIGITS{4'h9}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_EXP
   } state_e;

   state_e        state_q;
   logic [PW-1:0] presc_q;
   logic [W-1:0]  number_q;
   logic          dir_q;
   logic          running_q;
   logic          tick_q;
   logic          expired_q;
   logic          wrapped_q;

   logic [W-1:0]  load_d;
   logic [W-1:0]  dec_d;
   logic [W-1:0]  inc_d;
   logic          step_d;
   logic          can_start_d;
   logic          zero_down_d;

   function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] >= 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      load_d      = bcd_sat(load_val);
      dec_d       = bcd_dec(number_q);
      inc_d       = bcd_inc(number_q);
      step_d      = (presc_q == PMAX);
      can_start_d = (state_q == S_IDLE) || (state_q == S_PAUSE);
      zero_down_d = !dir_q && (number_q == '0);
   end

   // Commands are mutually exclusive by priority; RUN stepping only
   // happens in a cycle with no effective command.
   always_ff @(posedge clk_in or posedge reset_btn) begin
      if (reset_btn) begin
         state_q   <= S_IDLE;
         presc_q   <= '0;
         number_q  <= '0;
         dir_q     <= COUNT_UP;
         running_q <= 1'b0;
         tick_q    <= 1'b0;
         expired_q <= 1'b0;
         wrapped_q <= 1'b0;
      end else begin
         tick_q    <= 1'b0;
         expired_q <= 1'b0;
         wrapped_q <= 1'b0;
         if (clear) begin
            number_q  <= '0;
            presc_q   <= '0;
            dir_q     <= dir_up;
            state_q   <= S_IDLE;
            running_q <= 1'b0;
         end else if (load) begin
            number_q  <= load_d;
            presc_q   <= '0;
            dir_q     <= dir_up;
            state_q   <= S_IDLE;
            running_q <= 1'b0;
         end else if (pause) begin
            if (state_q == S_RUN) begin
               state_q   <= S_PAUSE;
               running_q <= 1'b0;
            end
         end else if (start && can_start_d) begin
            if (state_q == S_IDLE) presc_q <= '0;
            if (zero_down_d) begin
               state_q   <= S_EXP;
               running_q <= 1'b0;
            end else begin
               state_q   <= S_RUN;
               running_q <= 1'b1;
            end
         end else if (state_q == S_RUN) begin
            if (step_d) begin
               presc_q <= '0;
               tick_q  <= 1'b1;
               if (dir_q) begin
                  number_q  <= inc_d;
                  wrapped_q <= (number_q == NINES);
               end else begin
                  number_q <= dec_d;
                  if (dec_d == '0) begin
                     expired_q <= 1'b1;
                     state_q   <= S_EXP;
                     running_q <= 1'b0;
                  end
               end
            end else begin
               presc_q <= presc_q + 1'b1;
            end
         end
      end
   end

   assign number  = number_q;
   assign running = running_q;
   assign tick    = tick_q;
   assign expired = expired_q;
   assign wrapped = wrapped_q;

endmodule
